tr_pos_scan_sched: RTL and testbench

//  Round-robin scheduler that shares one position-sensor ADC between NUM_TR tuner channels.
//  - Starts one scan every scan_period clocks.
//  - For each enabled channel in a scan: requests a conversion, latches the result into that channel's x,

---
 rtl/tr_pkg.sv | 20 ++
 rtl/tr_period_tick.sv | 43 ++++
 rtl/tr_pos_scan_sched.sv | 144 ++++++++++++++
 tb/tb_tr_pos_scan_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared definitions for the tuner position-scan blocks: FSM encoding, default widths, channel-index width helper.
package tr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_LATCH,
    ST_STROBE
  } state_e;

  localparam int WIDTH_ADC_DEF = 12;
  localparam int WIDTH_X_DEF   = 32;

  // A single channel still needs a 1-bit select so the port never collapses to zero width.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tr_period_tick.sv
// Free-running period tick with a one-deep pending latch and sticky overrun; tick is combinational off the count.
// No backpressure: a tick arriving while one is still pending is dropped and flagged in overrun_o.
module tr_period_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] period_i,
  input  logic        clr_i,
  output logic        tick_o,
  output logic        pending_o,
  output logic        overrun_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lim;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;

  always_comb begin
    lim    = (period_i == 16'd0) ? 16'd1 : period_i;
    tick_o = en_i && (cnt_q == lim - 16'd1);
    cnt_d  = (!en_i || tick_o) ? 16'd0 : cnt_q + 16'd1;
    // A scan start and a tick in the same cycle leave exactly one tick pending.
    pending_d = en_i && ((pending_q && !clr_i) || tick_o);
    overrun_d = overrun_q || (tick_o && pending_q && !clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 16'd0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/tr_pos_scan_sched.sv
// Round-robin sharing of one position ADC across NUM_TR tuners; adc_ack -> x after 1 clk -> data_valid_TR after 2 clk.
// adc_req is held until adc_ack or TIMEOUT clocks; ticks that arrive while a scan is pending are flagged as overrun.
module tr_pos_scan_sched
  import tr_pkg::*;
#(
  parameter int NUM_TR    = 2,
  parameter int WIDTH_ADC = WIDTH_ADC_DEF,
  parameter int WIDTH_X   = WIDTH_X_DEF,
  parameter int TIMEOUT   = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scan_en,
  input  logic [15:0]               scan_period,
  input  logic [NUM_TR-1:0]         ch_mask,
  output logic                      adc_req,
  output logic [ch_w(NUM_TR)-1:0]   adc_ch,
  input  logic                      adc_ack,
  input  logic [WIDTH_ADC-1:0]      adc_data,
  output logic [NUM_TR*WIDTH_X-1:0] x,
  output logic [NUM_TR-1:0]         data_valid_TR,
  output logic [NUM_TR-1:0]         timeout_err,
  output logic                      overrun,
  output logic                      scan_busy
);

  localparam int CH_W  = ch_w(NUM_TR);
  localparam int PTR_W = CH_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e                    state_q;
  logic [PTR_W-1:0]          ptr_q;
  logic [TMR_W-1:0]          timer_q;
  logic [CH_W-1:0]           ch_q;
  logic [WIDTH_ADC-1:0]      cap_q;
  logic                      req_q;
  logic                      busy_q;
  logic [NUM_TR-1:0]         dv_q;
  logic [NUM_TR-1:0]         err_q;
  logic [NUM_TR*WIDTH_X-1:0] x_q;

  logic             pending;
  logic             tick;
  logic             start;
  logic             found;
  logic [CH_W-1:0]  sel_idx;
  logic [PTR_W-1:0] ptr_after;

  assign start = (state_q == ST_IDLE) && pending && scan_en;

  tr_period_tick u_tick (
    .clk       (clk),
    .rst       (rst),
    .en_i      (scan_en),
    .period_i  (scan_period),
    .clr_i     (start),
    .tick_o    (tick),
    .pending_o (pending),
    .overrun_o (overrun)
  );

  // Parallel priority search: descending loop so the lowest qualifying index wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = NUM_TR - 1; i >= 0; i--) begin
      if ((PTR_W'(i) >= ptr_q) && ch_mask[i]) begin
        found   = 1'b1;
        sel_idx = CH_W'(i);
      end
    end
    ptr_after = PTR_W'(ch_q) + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      ch_q    <= '0;
      cap_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      dv_q    <= '0;
      err_q   <= '0;
      x_q     <= '0;
    end else begin
      dv_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          // scan_en is only honoured here, so an open handshake always completes first.
          if (found && scan_en) begin
            ch_q    <= sel_idx;
            req_q   <= 1'b1;
            timer_q <= '0;
            state_q <= ST_REQ;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (adc_ack) begin
            cap_q   <= adc_data;
            req_q   <= 1'b0;
            state_q <= ST_LATCH;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            req_q       <= 1'b0;
            err_q[ch_q] <= 1'b1;
            ptr_q       <= ptr_after;
            state_q     <= ST_SELECT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_LATCH: begin
          x_q[int'(ch_q)*WIDTH_X +: WIDTH_X] <= WIDTH_X'(cap_q);
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          dv_q[ch_q] <= 1'b1;
          ptr_q      <= ptr_after;
          state_q    <= ST_SELECT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_req       = req_q;
  assign adc_ch        = ch_q;
  assign x             = x_q;
  assign data_valid_TR = dv_q;
  assign timeout_err   = err_q;
  assign scan_busy     = busy_q;

endmodule

// File: tb/tb_tr_pos_scan_sched.sv
// Directed bench for tr_pos_scan_sched: behavioural ADC responder plus a negedge monitor feeding per-test checks.
module tb_tr_pos_scan_sched;

  localparam int NUM_TR    = 2;
  localparam int WIDTH_ADC = 12;
  localparam int WIDTH_X   = 32;
  localparam int TIMEOUT   = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [15:0] scan_period;
  logic [1:0]  ch_mask;
  logic        adc_req;
  logic [0:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic [63:0] x;
  logic [1:0]  dv;
  logic [1:0]  terr;
  logic        overrun;
  logic        scan_busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  tr_pos_scan_sched #(
    .NUM_TR(NUM_TR), .WIDTH_ADC(WIDTH_ADC), .WIDTH_X(WIDTH_X), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_period(scan_period), .ch_mask(ch_mask),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .x(x), .data_valid_TR(dv), .timeout_err(terr), .overrun(overrun), .scan_busy(scan_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: acks lat negedges after adc_req rises, only for channels with resp_on set.
  int          lat = 5;
  logic [1:0]  resp_on = 2'b11;
  logic [11:0] resp_data [2];
  int          wcnt;

  initial begin
    adc_ack  = 1'b0;
    adc_data = '0;
    wcnt     = 0;
    forever begin
      @(negedge clk);
      if (adc_ack) begin
        adc_ack = 1'b0;
      end else if (adc_req && resp_on[adc_ch]) begin
        wcnt++;
        if (wcnt >= lat) begin
          adc_ack  = 1'b1;
          adc_data = resp_data[adc_ch];
          wcnt     = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  int clr_gen = 0, clr_seen = 0;
  int dv_cnt [2], req_cnt [2], req_len [2];
  int min_len, max_len, cur_len, x_unstable, dv_wide, ch_glitch, busy_rises, dv_n;
  int busy_t [2], dv_seq [4];
  logic [63:0] x_prev;
  logic [1:0]  dv_prev;
  logic        req_prev, busy_prev;
  logic [0:0]  ch_prev;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      for (int i = 0; i < 2; i++) begin
        dv_cnt[i] = 0; req_cnt[i] = 0; req_len[i] = 0; busy_t[i] = 0;
      end
      for (int i = 0; i < 4; i++) dv_seq[i] = -1;
      min_len = 1000000; max_len = 0; cur_len = 0; x_unstable = 0; dv_wide = 0;
      ch_glitch = 0; busy_rises = 0; dv_n = 0;
      clr_seen = clr_gen;
    end else begin
      if (dv != 2'b00 && x !== x_prev) x_unstable++;
      if ((dv & dv_prev) != 2'b00) dv_wide++;
      for (int i = 0; i < 2; i++) begin
        if (dv[i]) begin
          dv_cnt[i]++;
          if (dv_n < 4) dv_seq[dv_n] = i;
          dv_n++;
        end
      end
      if (adc_req && !req_prev) req_cnt[adc_ch]++;
      if (adc_req && req_prev && adc_ch !== ch_prev) ch_glitch++;
      if (adc_req) begin
        cur_len++;
      end else if (req_prev) begin
        req_len[ch_prev] = cur_len;
        if (cur_len < min_len) min_len = cur_len;
        if (cur_len > max_len) max_len = cur_len;
        cur_len = 0;
      end
      if (scan_busy && !busy_prev) begin
        if (busy_rises < 2) busy_t[busy_rises] = cyc;
        busy_rises++;
      end
    end
    x_prev = x; dv_prev = dv; req_prev = adc_req; ch_prev = adc_ch; busy_prev = scan_busy;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scan_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clr_stats();
    clr_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; scan_period = 16'd0; ch_mask = 2'b00;
    repeat (3) @(negedge clk);
    n_total++; if (adc_req !== 1'b0) $display("FAIL reset_adc_req got %b want 0", adc_req); else n_pass++;
    n_total++; if (x !== 64'd0) $display("FAIL reset_x got %h want 0", x); else n_pass++;
    n_total++; if ({dv, terr} !== 4'b0) $display("FAIL reset_dv_err got %b want 0000", {dv, terr}); else n_pass++;
    n_total++; if ({overrun, scan_busy} !== 2'b00) $display("FAIL reset_flags got %b want 00", {overrun, scan_busy}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    int k;
    do_reset(); clr_stats();
    ch_mask = 2'b11; scan_period = 16'd100; lat = 5; resp_on = 2'b11; scan_en = 1'b1;
    k = 0; while (!(dv_cnt[1] >= 1) && k < 300) begin @(negedge clk); k++; end
    n_total++; if (dv_cnt[1] < 1) $display("FAIL basic_wait dv1 count %0d want >=1", dv_cnt[1]); else n_pass++;
    n_total++; if (x[31:0] !== 32'h123) $display("FAIL basic_x0 got %h want 123", x[31:0]); else n_pass++;
    n_total++; if (x[63:32] !== 32'h456) $display("FAIL basic_x1 got %h want 456", x[63:32]); else n_pass++;
    n_total++; if (dv_seq[0] !== 0 || dv_seq[1] !== 1) $display("FAIL basic_dv_order got %0d,%0d want 0,1", dv_seq[0], dv_seq[1]); else n_pass++;
    n_total++; if (dv_cnt[0] !== 1) $display("FAIL basic_dv0_count got %0d want 1", dv_cnt[0]); else n_pass++;
    n_total++; if (dv_wide !== 0) $display("FAIL basic_dv_width wide pulses %0d want 0", dv_wide); else n_pass++;
    n_total++; if (x_unstable !== 0) $display("FAIL basic_x_setup unstable %0d want 0", x_unstable); else n_pass++;
    n_total++; if (min_len !== 5 || max_len !== 5) $display("FAIL basic_req_len got %0d..%0d want 5", min_len, max_len); else n_pass++;
    k = 0; while (!(busy_rises >= 2) && k < 300) begin @(negedge clk); k++; end
    n_total++; if (busy_t[1] - busy_t[0] !== 100) $display("FAIL basic_period got %0d want 100 (scans %0d)", busy_t[1] - busy_t[0], busy_rises); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL basic_overrun got %b want 0", overrun); else n_pass++;
    scan_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(); clr_stats();
    ch_mask = 2'b11; scan_period = 16'd3; lat = 20; scan_en = 1'b1;
    repeat (400) @(negedge clk);
    n_total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got %b want 1", overrun); else n_pass++;
    n_total++; if (busy_rises < 7) $display("FAIL b2b_scans got %0d want >=7", busy_rises); else n_pass++;
    n_total++; if (ch_glitch !== 0) $display("FAIL b2b_ch_glitch got %0d want 0", ch_glitch); else n_pass++;
    n_total++; if (min_len !== 20 || max_len !== 20) $display("FAIL b2b_req_len got %0d..%0d want 20", min_len, max_len); else n_pass++;
    scan_en = 1'b0;
  endtask

  task automatic test_mask();
    int k;
    do_reset(); clr_stats();
    ch_mask = 2'b10; scan_period = 16'd100; lat = 5; scan_en = 1'b1;
    k = 0; while (!(dv_cnt[1] >= 1) && k < 300) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    n_total++; if (req_cnt[0] !== 0 || req_cnt[1] !== 1) $display("FAIL mask_reqs got %0d,%0d want 0,1", req_cnt[0], req_cnt[1]); else n_pass++;
    n_total++; if (x[31:0] !== 32'h0) $display("FAIL mask_x0 got %h want 0", x[31:0]); else n_pass++;
    n_total++; if (x[63:32] !== 32'h456) $display("FAIL mask_x1 got %h want 456", x[63:32]); else n_pass++;
    n_total++; if (dv_cnt[0] !== 0) $display("FAIL mask_dv0 got %0d want 0", dv_cnt[0]); else n_pass++;
    scan_en = 1'b0;
  endtask

  task automatic test_scan_en_drop();
    int k;
    do_reset(); clr_stats();
    ch_mask = 2'b11; scan_period = 16'd10; lat = 20; scan_en = 1'b1;
    k = 0; while (!(adc_req && adc_ch == 1'b0) && k < 100) begin @(negedge clk); k++; end
    n_total++; if (!(adc_req && adc_ch == 1'b0)) $display("FAIL drop_wait_req req %b ch %b want 1 0", adc_req, adc_ch); else n_pass++;
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    repeat (100) @(negedge clk);
    n_total++; if (dv_cnt[0] !== 1 || dv_cnt[1] !== 0) $display("FAIL drop_dv got %0d,%0d want 1,0", dv_cnt[0], dv_cnt[1]); else n_pass++;
    n_total++; if (req_cnt[1] !== 0) $display("FAIL drop_ch1_req got %0d want 0", req_cnt[1]); else n_pass++;
    n_total++; if (x[31:0] !== 32'h123) $display("FAIL drop_x0 got %h want 123", x[31:0]); else n_pass++;
    n_total++; if ({adc_req, scan_busy} !== 2'b00) $display("FAIL drop_idle got %b want 00", {adc_req, scan_busy}); else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    do_reset(); clr_stats();
    resp_on = 2'b10; ch_mask = 2'b11; scan_period = 16'd3000; lat = 5; scan_en = 1'b1;
    k = 0; while (!(dv_cnt[1] >= 1) && k < 5000) begin @(negedge clk); k++; end
    n_total++; if (dv_cnt[1] !== 1) $display("FAIL to_dv1 got %0d want 1", dv_cnt[1]); else n_pass++;
    n_total++; if (req_len[0] !== TIMEOUT) $display("FAIL to_req_len got %0d want %0d", req_len[0], TIMEOUT); else n_pass++;
    n_total++; if (terr !== 2'b01) $display("FAIL to_err got %b want 01", terr); else n_pass++;
    n_total++; if (x[31:0] !== 32'h0) $display("FAIL to_x0 got %h want 0", x[31:0]); else n_pass++;
    n_total++; if (x[63:32] !== 32'h456) $display("FAIL to_x1 got %h want 456", x[63:32]); else n_pass++;
    n_total++; if (dv_cnt[0] !== 0) $display("FAIL to_dv0 got %0d want 0", dv_cnt[0]); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int k;
    @(negedge clk);
    scan_en = 1'b0; resp_on = 2'b11;
    @(negedge clk);
    scan_period = 16'd3; lat = 20; scan_en = 1'b1;
    k = 0; while (!adc_req && k < 100) begin @(negedge clk); k++; end
    repeat (8) @(negedge clk);
    n_total++; if ({adc_req, overrun, terr} !== 4'b1101) $display("FAIL rstmid_pre got %b want 1101", {adc_req, overrun, terr}); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (adc_req !== 1'b0) $display("FAIL rstmid_req got %b want 0", adc_req); else n_pass++;
    n_total++; if (x !== 64'd0) $display("FAIL rstmid_x got %h want 0", x); else n_pass++;
    n_total++; if ({terr, overrun, scan_busy} !== 4'b0000) $display("FAIL rstmid_flags got %b want 0000", {terr, overrun, scan_busy}); else n_pass++;
    scan_en = 1'b0;
  endtask

  initial begin
    resp_data[0] = 12'h123;
    resp_data[1] = 12'h456;
    test_reset();
    test_basic_scan();
    test_back_to_back();
    test_mask();
    test_scan_en_drop();
    test_timeout();
    test_rst_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
